// File: rtl/sram_like_pkg.sv
// Shared types for the sram-like arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE, REQ, WAIT_DATA)
//   owner_t     : which requester owns the current transaction
//   SZ_*        : transfer size encodings used on the *_size ports
package sram_like_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant decision for the sram-like arbiter.
// Decides which requester wins when the arbiter is idle and keeps the
// fairness state that the decision depends on.
//   clk, rst      : clock, asynchronous active-high reset
//   inst_req      : fetch requester is asking
//   data_req      : data requester is asking
//   grant_strobe  : a grant is being taken this cycle (updates fairness state)
//   grant_data    : 1 = data wins, 0 = inst wins (only meaningful with a req)
// Build option SRAM_ARB_RR_EN: round-robin on contention using a 1-bit
// last_grant register. Default: data priority with a starvation counter that
// forces an inst grant after STARVE_LIMIT data grants while inst waited.
module sram_arb_grant
    import sram_like_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inst_req,
    input  logic data_req,
    input  logic grant_strobe,
    output logic grant_data
);

`ifdef SRAM_ARB_RR_EN

    owner_t last_grant;

    // On contention the requester not served last wins.
    always_comb begin
        if (inst_req && data_req) begin
            grant_data = (last_grant == OWN_INST);
        end else begin
            grant_data = data_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWN_INST;
        end else if (grant_strobe) begin
            last_grant <= grant_data ? OWN_DATA : OWN_INST;
        end
    end

`else

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    // Data wins unless inst has been passed over LIMIT times in a row.
    always_comb begin
        grant_data = data_req && !(inst_req && (starve_cnt == LIMIT));
    end

    // Counts data grants taken while inst was waiting; saturates at LIMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_strobe) begin
            if (grant_data) begin
                if (inst_req && (starve_cnt != LIMIT)) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like master port between instruction-fetch and
// data-memory requesters, one outstanding transaction at a time.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   inst_* / data_*             : requester groups (req, wr, size, addr, wdata in;
//                                 addr_ok, data_ok, rdata out)
//   m_req/m_wr/m_size/m_addr/m_wdata : master request side (from latched fields)
//   m_addr_ok/m_data_ok/m_rdata : master response side
//   busy                        : arbiter not idle
// Build option SRAM_ARB_RR_EN selects round-robin arbitration (see sram_arb_grant).
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          inst_req,
    input  logic          inst_wr,
    input  logic [1:0]    inst_size,
    input  logic [AW-1:0] inst_addr,
    input  logic [DW-1:0] inst_wdata,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,

    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,

    output logic          m_req,
    output logic          m_wr,
    output logic [1:0]    m_size,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_addr_ok,
    input  logic          m_data_ok,
    input  logic [DW-1:0] m_rdata,

    output logic          busy
);

    arb_state_t    state;
    owner_t        owner;
    logic          wr_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic grant_strobe;
    logic grant_data;

    assign grant_strobe = (state == IDLE) && (inst_req || data_req);

    sram_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .data_req     (data_req),
        .grant_strobe (grant_strobe),
        .grant_data   (grant_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= OWN_INST;
            m_req   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_req || data_req) begin
                        state <= REQ;
                        m_req <= 1'b1;
                        if (grant_data) begin
                            owner   <= OWN_DATA;
                            wr_q    <= data_wr;
                            size_q  <= data_size;
                            addr_q  <= data_addr;
                            wdata_q <= data_wdata;
                        end else begin
                            owner   <= OWN_INST;
                            wr_q    <= inst_wr;
                            size_q  <= inst_size;
                            addr_q  <= inst_addr;
                            wdata_q <= inst_wdata;
                        end
                    end
                end
                REQ: begin
                    if (m_addr_ok) begin
                        state <= WAIT_DATA;
                        m_req <= 1'b0;
                    end
                end
                WAIT_DATA: begin
                    if (m_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

    assign m_wr    = wr_q;
    assign m_size  = size_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign busy    = (state != IDLE);

    // Handshakes are passed through combinationally, gated by phase and owner,
    // so stray m_addr_ok/m_data_ok in the wrong phase never reach a requester.
    assign inst_addr_ok = (state == REQ)       && m_addr_ok && (owner == OWN_INST);
    assign data_addr_ok = (state == REQ)       && m_addr_ok && (owner == OWN_DATA);
    assign inst_data_ok = (state == WAIT_DATA) && m_data_ok && (owner == OWN_INST);
    assign data_data_ok = (state == WAIT_DATA) && m_data_ok && (owner == OWN_DATA);

    // Read data goes to both requesters; the data_ok pulse qualifies it.
    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios with literal
// expectations plus a transaction-level model checked every cycle.
module tb_sram_like_arbiter;
    import sram_like_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned STARVE_LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req, inst_wr;
    logic [1:0]    inst_size;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_wdata;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          m_req, m_wr;
    logic [1:0]    m_size;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_addr_ok, m_data_ok;
    logic [DW-1:0] m_rdata;
    logic          busy;

    sram_like_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 = no transaction, 1 = address offered, 2 = awaiting data
    int          md_phase = 0;
    bit          md_own_data = 1'b0;
    int unsigned md_passed = 0;      // data wins in a row while inst waited
    bit          md_last_data = 1'b0;
    logic        md_wr = 1'b0;
    logic [1:0]  md_size = '0;
    logic [31:0] md_addr = '0;
    logic [31:0] md_wdata = '0;

    always @(negedge clk) begin
        if (rst) begin
            md_phase = 0; md_own_data = 1'b0; md_passed = 0; md_last_data = 1'b0;
            chk("rst_busy", busy, 0);
            chk("rst_m_req", m_req, 0);
            chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        end else begin
            bit e_iao, e_dao, e_ido, e_ddo;
            e_iao = (md_phase == 1) && m_addr_ok && !md_own_data;
            e_dao = (md_phase == 1) && m_addr_ok &&  md_own_data;
            e_ido = (md_phase == 2) && m_data_ok && !md_own_data;
            e_ddo = (md_phase == 2) && m_data_ok &&  md_own_data;
            chk("mdl_busy", busy, md_phase != 0);
            chk("mdl_m_req", m_req, md_phase == 1);
            if (md_phase == 1) begin
                chk("mdl_m_wr", m_wr, md_wr);
                chk("mdl_m_size", m_size, md_size);
                chk("mdl_m_addr", m_addr, md_addr);
                chk("mdl_m_wdata", m_wdata, md_wdata);
            end
            chk("mdl_inst_addr_ok", inst_addr_ok, e_iao);
            chk("mdl_data_addr_ok", data_addr_ok, e_dao);
            chk("mdl_inst_data_ok", inst_data_ok, e_ido);
            chk("mdl_data_data_ok", data_data_ok, e_ddo);
            if (e_ido) chk("mdl_inst_rdata", inst_rdata, m_rdata);
            if (e_ddo) chk("mdl_data_rdata", data_rdata, m_rdata);

            case (md_phase)
                0: if (inst_req || data_req) begin
                    bit g;
                    if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
                        g = !md_last_data;
`else
                        g = (md_passed < STARVE_LIMIT);
`endif
                    end else begin
                        g = data_req;
                    end
                    md_last_data = g;
                    if (!g) md_passed = 0;
                    else if (inst_req && md_passed < STARVE_LIMIT) md_passed++;
                    md_own_data = g;
                    md_wr    = g ? data_wr    : inst_wr;
                    md_size  = g ? data_size  : inst_size;
                    md_addr  = g ? data_addr  : inst_addr;
                    md_wdata = g ? data_wdata : inst_wdata;
                    md_phase = 1;
                end
                1: if (m_addr_ok) md_phase = 2;
                2: if (m_data_ok) md_phase = 0;
                default: md_phase = 0;
            endcase
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Acts as the bridge for one transaction; reports whether data owned it.
    task automatic serve(input logic [31:0] rd, output bit is_data);
        int t = 0;
        while (!m_req && t < 20) begin
            cyc();
            t++;
        end
        chk("serve_m_req_seen", m_req, 1);
        is_data = (m_addr[31:28] == 4'h8);
        m_addr_ok = 1'b1;
        cyc();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = rd;
        cyc();
        m_data_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit seq [0:10];
    bit exp_seq [0:10];

    initial begin
        rst = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = SZ_WORD; data_addr = '0; data_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_req", m_req, 0);
        chk("reset_m_fields", {m_wr, m_size, m_addr}, 0);
        chk("reset_m_wdata", m_wdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        rst = 1'b0;

        // 1: single inst fetch; bridge answers at cycles 3 and 5
        inst_req = 1; inst_addr = 32'hBFC00000;                        // cycle 0
        cyc(); #1;                                                     // cycle 1
        chk("t1_m_req_c1", m_req, 1);
        chk("t1_m_addr", m_addr, 32'hBFC00000);
        cyc();                                                         // cycle 2
        cyc(); m_addr_ok = 1; #1;                                      // cycle 3
        chk("t1_inst_addr_ok", inst_addr_ok, 1);
        chk("t1_data_addr_ok", data_addr_ok, 0);
        cyc(); m_addr_ok = 0; inst_req = 0; #1;                        // cycle 4
        chk("t1_m_req_dropped", m_req, 0);
        cyc(); m_data_ok = 1; m_rdata = 32'h3C1DBFC0; #1;              // cycle 5
        chk("t1_inst_data_ok", inst_data_ok, 1);
        chk("t1_inst_rdata", inst_rdata, 32'h3C1DBFC0);
        chk("t1_data_data_ok", data_data_ok, 0);
        cyc(); m_data_ok = 0; #1;
        chk("t1_idle", busy, 0);

        // 2: contention, data write wins, inst follows after data_ok
        inst_req = 1; inst_addr = 32'hBFC00004;
        data_req = 1; data_wr = 1; data_size = SZ_WORD;
        data_addr = 32'h80001000; data_wdata = 32'h12345678;
        cyc(); #1;
        chk("t2_m_req", m_req, 1);
        chk("t2_m_wr", m_wr, 1);
        chk("t2_m_addr", m_addr, 32'h80001000);
        chk("t2_m_wdata", m_wdata, 32'h12345678);
        chk("t2_m_size", m_size, SZ_WORD);
        m_addr_ok = 1; #1;
        chk("t2_data_addr_ok", data_addr_ok, 1);
        chk("t2_inst_addr_ok", inst_addr_ok, 0);
        cyc(); m_addr_ok = 0; data_req = 0; data_wr = 0;
        cyc(); m_data_ok = 1; m_rdata = 32'hCAFE0001; #1;
        chk("t2_data_data_ok", data_data_ok, 1);
        chk("t2_inst_data_ok", inst_data_ok, 0);
        cyc(); m_data_ok = 0; #1;
        chk("t2_gap_idle", busy, 0);
        cyc(); #1;
        chk("t2_inst_m_req", m_req, 1);
        chk("t2_inst_m_addr", m_addr, 32'hBFC00004);
        chk("t2_inst_m_wr", m_wr, 0);
        m_addr_ok = 1;
        cyc(); m_addr_ok = 0; inst_req = 0;
        cyc(); m_data_ok = 1; m_rdata = 32'h00000013; #1;
        chk("t2_inst_data_ok", inst_data_ok, 1);
        cyc(); m_data_ok = 0;

        // 3 / 6: both requesters held continuously
        inst_req = 1; inst_addr = 32'hBFC00100;
        data_req = 1; data_wr = 0; data_addr = 32'h80002000;
        for (int i = 0; i < 11; i++) begin
            bit g;
            serve(32'h1000 + i, g);
            seq[i] = g;
        end
        inst_req = 0; data_req = 0;
`ifdef SRAM_ARB_RR_EN
        exp_seq = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
`endif
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t3_grant_%0d_is_data", i), seq[i], exp_seq[i]);
        end

        // 4: stray handshakes in the wrong phase
        cyc(); inst_req = 1; inst_addr = 32'hBFC00200;
        cyc();
        m_data_ok = 1; #1;
        chk("t4_stray_data_ok", {inst_data_ok, data_data_ok}, 0);
        cyc(); m_data_ok = 0; #1;
        chk("t4_still_req", {m_req, busy}, 2'b11);
        m_addr_ok = 1;
        cyc(); inst_req = 0; #1;                        // now awaiting data, m_addr_ok still high
        chk("t4_stray_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        cyc(); m_addr_ok = 0; #1;
        chk("t4_still_wait", {m_req, busy}, 2'b01);
        m_data_ok = 1; m_rdata = 32'hA5A5A5A5; #1;
        chk("t4_inst_data_ok", inst_data_ok, 1);
        cyc(); m_data_ok = 0;

        // 5: asynchronous reset while awaiting data
        inst_req = 1; inst_addr = 32'hBFC00300;
        cyc();
        m_addr_ok = 1;
        cyc(); m_addr_ok = 0; inst_req = 0; m_data_ok = 1;
        #2 rst = 1;
        #1;
        chk("t5_rst_m_req", m_req, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        cyc(); rst = 0; m_data_ok = 0; inst_req = 1; inst_addr = 32'hBFC00400;
        cyc(); #1;
        chk("t5_fresh_m_req", m_req, 1);
        chk("t5_fresh_m_addr", m_addr, 32'hBFC00400);
        m_addr_ok = 1;
        cyc(); m_addr_ok = 0; inst_req = 0;
        cyc(); m_data_ok = 1; m_rdata = 32'h55AA55AA;
        cyc(); m_data_ok = 0;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
